// File: rtl/ysyx_lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, response error codes and FSM states.
package ysyx_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_MIS = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_RESP = 2'b11
  } lsu_state_e;

  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/ysyx_lsu_align.sv
// Byte-lane steering: store mask/data placement and load data shift plus sign/zero extension.
module ysyx_lsu_align
  import ysyx_lsu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NB    = XLEN / 8,
  parameter int unsigned OFF_W = $clog2(NB)
) (
  input  logic [OFF_W-1:0] offset_i,
  input  logic [1:0]       size_i,
  input  logic             unsigned_i,
  input  logic             store_i,
  input  logic [XLEN-1:0]  wdata_i,
  input  logic [XLEN-1:0]  rdata_i,
  output logic [NB-1:0]    wmask_o,
  output logic [XLEN-1:0]  wdata_o,
  output logic [XLEN-1:0]  rdata_o
);

  logic [3:0]      bytes;
  logic [NB-1:0]   lane_mask;
  logic [XLEN-1:0] rsh;
  logic            sign_bit;
  int unsigned     nbits;

  always_comb begin
    bytes     = size_bytes(size_i);
    nbits     = 32'(bytes) * 8;
    lane_mask = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < int'(bytes)) lane_mask[i] = 1'b1;
    end
    wmask_o = store_i ? (lane_mask << offset_i) : '0;
    wdata_o = wdata_i << {offset_i, 3'b000};

    rsh = rdata_i >> {offset_i, 3'b000};
    case (size_i)
      SZ_B:    sign_bit = rsh[7];
      SZ_H:    sign_bit = rsh[15];
      SZ_W:    sign_bit = rsh[31];
      default: sign_bit = 1'b0;
    endcase
    sign_bit = sign_bit & ~unsigned_i;

    // Bits above the access width are replaced by the extension bit; dword passes through.
    rdata_o = rsh;
    for (int i = 0; i < XLEN; i++) begin
      if (i >= int'(nbits)) rdata_o[i] = sign_bit;
    end
  end

endmodule

// File: rtl/ysyx_lsu.sv
// Load/store unit: one-at-a-time valid/ready bus master with misalignment and timeout errors.
// state   | meaning
// IDLE    | req_ready high, waiting for an EXU request
// REQ     | bus request presented, held until mem_req_ready
// WAIT    | waiting for mem_rsp_valid, counting towards TIMEOUT
// RESP    | response presented to EXU until resp_ready
module ysyx_lsu
  import ysyx_lsu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_store,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [XLEN-1:0]      req_wdata,
  input  logic [4:0]           req_rd,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [XLEN-1:0]      resp_rdata,
  output logic [4:0]           resp_rd,
  output logic [1:0]           resp_err,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [XLEN-1:0]      mem_wdata,
  output logic [XLEN/8-1:0]    mem_wmask,
  input  logic                 mem_rsp_valid,
  input  logic [XLEN-1:0]      mem_rdata
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              store_q, store_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [1:0]        err_q, err_d;

  logic [NB-1:0]     al_wmask;
  logic [XLEN-1:0]   al_wdata;
  logic [XLEN-1:0]   al_rdata;
  logic [3:0]        req_bytes;
  logic              req_bad;

  ysyx_lsu_align #(
    .XLEN (XLEN)
  ) u_align (
    .offset_i   (addr_q[OFF_W-1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .store_i    (store_q),
    .wdata_i    (wdata_q),
    .rdata_i    (mem_rdata),
    .wmask_o    (al_wmask),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata)
  );

  always_comb begin
    req_bytes = size_bytes(req_size);
    req_bad   = (|(req_addr[OFF_W-1:0] & OFF_W'(req_bytes - 4'd1)))
              || ((req_size == SZ_D) && (XLEN == 32));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    store_d = store_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_inc = cnt_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          store_d = req_store;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rd_d    = req_rd;
          rdata_d = '0;
          if (req_bad) begin
            err_d   = ERR_MIS;
            state_d = ST_RESP;
          end else begin
            err_d   = ERR_OK;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_inc;
        // A response landing on the timeout cycle still counts as a good response.
        if (mem_rsp_valid) begin
          rdata_d = store_q ? '0 : al_rdata;
          err_d   = ERR_OK;
          state_d = ST_RESP;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          rdata_d = '0;
          err_d   = ERR_TMO;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      store_q <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      store_q <= store_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    req_ready     = (state_q == ST_IDLE);
    mem_req_valid = (state_q == ST_REQ);
    mem_we        = mem_req_valid && store_q;
    mem_addr      = mem_req_valid ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    mem_wdata     = mem_we ? al_wdata : '0;
    mem_wmask     = mem_req_valid ? al_wmask : '0;
    resp_valid    = (state_q == ST_RESP);
    resp_rdata    = resp_valid ? rdata_q : '0;
    resp_rd       = resp_valid ? rd_q : '0;
    resp_err      = resp_valid ? err_q : '0;
  end

endmodule

// File: tb/tb_ysyx_lsu.sv
// Self-checking bench for ysyx_lsu (XLEN=32, TIMEOUT=4) against a behavioural transaction model.
module tb_ysyx_lsu;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic [1:0]  resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ysyx_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_rd(resp_rd), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: pick the addressed bytes arithmetically, then sign-extend by subtraction.
  function automatic logic [31:0] model_load(input logic [31:0] mrd, input int sz,
                                             input bit uns, input int off);
    longint v, span;
    int nb;
    nb   = 1 << sz;
    span = 64'd1 << (8 * nb);
    v    = (longint'(mrd) >> (8 * off)) % span;
    if (!uns && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  task automatic do_txn(input bit st, input int sz, input bit uns, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] mrd, input logic [4:0] rd,
                        input int rdy_dly, input int rsp_dly, input int resp_dly,
                        input string tag);
    int          nb, off;
    bit          bad;
    logic [3:0]  exp_mask;
    logic [31:0] exp_wd, exp_rd, exp_addr;
    logic [1:0]  exp_err;
    nb       = 1 << sz;
    off      = int'(addr % 4);
    bad      = (sz == 3) || (addr % nb != 0);
    exp_mask = '0;
    for (int i = 0; i < nb; i++) if (st && off + i < 4) exp_mask[off + i] = 1'b1;
    exp_wd   = wdata << (8 * off);
    exp_addr = addr - (addr % 4);
    exp_rd   = (st || bad) ? 32'h0 : model_load(mrd, sz, uns, off);
    exp_err  = bad ? 2'b01 : 2'b00;

    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s idle_ready: got %b want 1", tag, req_ready);
    end
    req_valid = 1'b1; req_store = st; req_size = sz[1:0]; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    step();
    req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom;

    if (bad) begin
      vectors++;
      if (mem_req_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL %s mis_no_bus: mem_req_valid got %b want 0", tag, mem_req_valid);
      end
    end else begin
      for (int k = 0; k <= rdy_dly; k++) begin
        vectors++;
        if (mem_req_valid !== 1'b1 || mem_addr !== exp_addr || mem_wmask !== exp_mask ||
            mem_we !== st || (st && mem_wdata !== exp_wd) || resp_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL %s bus_req[%0d]: got v=%b a=%h m=%b we=%b d=%h want v=1 a=%h m=%b we=%b d=%h",
                   tag, k, mem_req_valid, mem_addr, mem_wmask, mem_we, mem_wdata,
                   exp_addr, exp_mask, st, exp_wd);
        end
        mem_req_ready = (k == rdy_dly);
        step();
      end
      mem_req_ready = 1'b0;
      for (int k = 0; k <= rsp_dly; k++) begin
        vectors++;
        if (mem_req_valid !== 1'b0 || resp_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL %s wait[%0d]: got mem_req_valid=%b resp_valid=%b want 0 0",
                   tag, k, mem_req_valid, resp_valid);
        end
        mem_rsp_valid = (k == rsp_dly);
        mem_rdata     = (k == rsp_dly) ? mrd : $urandom;
        step();
      end
      mem_rsp_valid = 1'b0;
      mem_rdata     = $urandom;
    end

    for (int k = 0; k <= resp_dly; k++) begin
      vectors++;
      if (resp_valid !== 1'b1 || resp_rdata !== exp_rd || resp_rd !== rd ||
          resp_err !== exp_err || req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL %s resp[%0d]: got v=%b d=%h rd=%0d e=%b rr=%b want v=1 d=%h rd=%0d e=%b rr=0",
                 tag, k, resp_valid, resp_rdata, resp_rd, resp_err, req_ready,
                 exp_rd, rd, exp_err);
      end
      resp_ready = (k == resp_dly);
      req_valid  = 1'b1;
      step();
    end
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s after_resp: got req_ready=%b resp_valid=%b want 1 0", tag, req_ready, resp_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_req_valid !== 1'b0 ||
        mem_we !== 1'b0 || mem_wmask !== 4'b0 || resp_rdata !== 32'h0 || resp_err !== 2'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rr=%b rv=%b mv=%b we=%b m=%b d=%h e=%b want 1 0 0 0 0 0 0",
               req_ready, resp_valid, mem_req_valid, mem_we, mem_wmask, resp_rdata, resp_err);
    end
    rst_n = 1'b1;
    step();

    // Reset asserted while waiting for the bus response.
    req_valid = 1'b1; req_store = 1'b0; req_size = 2'b10; req_addr = 32'h8000_0010; req_rd = 5'd7;
    step();
    req_valid = 1'b0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1 || mem_req_valid !== 1'b0 || resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_wait: got rr=%b mv=%b rv=%b want 1 0 0", req_ready, mem_req_valid, resp_valid);
    end
    step();
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1;
    step();
    mem_rsp_valid = 1'b0;
    step();
    vectors++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_no_resp: got rv=%b rr=%b want 0 1", resp_valid, req_ready);
    end

    // Reset while the bus request is stalled drops the request.
    req_valid = 1'b1; req_store = 1'b1;
    step();
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (mem_req_valid !== 1'b0 || mem_we !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_req: got mv=%b we=%b rr=%b want 0 0 1", mem_req_valid, mem_we, req_ready);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_directed();
    do_txn(1'b0, 0, 1'b0, 32'h8000_0003, 32'h0, 32'h80FF_0000, 5'd1, 0, 0, 0, "lb");
    do_txn(1'b0, 0, 1'b1, 32'h8000_0003, 32'h0, 32'h80FF_0000, 5'd2, 0, 0, 0, "lbu");
    do_txn(1'b1, 1, 1'b0, 32'h8000_0002, 32'h0000_1234, 32'hDEAD_BEEF, 5'd3, 0, 0, 0, "sh");
    do_txn(1'b0, 2, 1'b0, 32'h8000_0002, 32'h0, 32'h1111_1111, 5'd4, 0, 0, 0, "lw_mis");
    do_txn(1'b0, 3, 1'b0, 32'h8000_0000, 32'h0, 32'h1111_1111, 5'd5, 0, 0, 0, "ld_illegal");
    do_txn(1'b1, 2, 1'b0, 32'h8000_0104, 32'hCAFE_F00D, 32'h0, 5'd6, 5, 1, 2, "sw_stall");
    do_txn(1'b0, 1, 1'b0, 32'h8000_0002, 32'h0, 32'h8001_7FFF, 5'd8, 0, 3, 0, "lh_rsp_on_tmo");
  endtask

  task automatic test_timeout();
    req_valid = 1'b1; req_store = 1'b0; req_size = 2'b10; req_addr = 32'h8000_0020; req_rd = 5'd9;
    step();
    req_valid = 1'b0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int k = 0; k < TMO; k++) begin
      vectors++;
      if (resp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL tmo_early[%0d]: got resp_valid=%b want 0", k, resp_valid);
      end
      step();
    end
    vectors++;
    if (resp_valid !== 1'b1 || resp_err !== 2'b10 || resp_rdata !== 32'h0 || resp_rd !== 5'd9) begin
      miscompares++;
      $display("FAIL tmo_resp: got v=%b e=%b d=%h rd=%0d want 1 10 0 9", resp_valid, resp_err, resp_rdata, resp_rd);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_rsp_valid = 1'b0;
    step();
    vectors++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL tmo_late_rsp: got rv=%b rr=%b mv=%b want 0 1 0", resp_valid, req_ready, mem_req_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      do_txn(i[0], i % 3, i[1], 32'h8000_0040 + 32'(4 * i), $urandom, $urandom, 5'(i + 10),
             0, 0, 0, "b2b");
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      int sz;
      logic [31:0] a;
      sz = $urandom_range(0, 3);
      a  = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 1);
      do_txn($urandom_range(0, 1) == 1, sz, $urandom_range(0, 1) == 1, a, $urandom, $urandom,
             5'($urandom), $urandom_range(0, 3), $urandom_range(0, TMO - 1),
             $urandom_range(0, 2), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
